qpu_exu_flush_ctrl: RTL and testbench

QPU_EXU_FLUSH_CTRL -- requirements
Module: QPU_exu_flush_ctrl

---
 rtl/qpu_exu_flush_ctrl_pkg.sv | 24 ++
 rtl/qpu_gnrl_dfflr.sv | 24 ++
 rtl/qpu_exu_flush_ctrl.sv | 101 ++++++++++
 tb/tb_qpu_exu_flush_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_exu_flush_ctrl_pkg.sv
`default_nettype none
// qpu_exu_flush_ctrl_pkg: shared PC width and the flush-controller state encoding.
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_FLUSH_ST_IDLE
`define QPU_FLUSH_ST_IDLE 1'b0
`endif
`ifndef QPU_FLUSH_ST_REQ
`define QPU_FLUSH_ST_REQ 1'b1
`endif

package qpu_exu_flush_ctrl_pkg;

  localparam int PC_W = `QPU_PC_SIZE;

  typedef enum logic {
    ST_IDLE = `QPU_FLUSH_ST_IDLE,
    ST_REQ  = `QPU_FLUSH_ST_REQ
  } flush_state_e;

endpackage

`default_nettype wire

// File: rtl/qpu_gnrl_dfflr.sv
`default_nettype none
// qpu_gnrl_dfflr: generic load-enabled flop, asynchronously cleared to zero.

module qpu_gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/qpu_exu_flush_ctrl.sv
`default_nettype none
// qpu_exu_flush_ctrl: arbitrates branch-mispredict and redirect flushes into one
// registered IFU flush handshake, with a kill pulse and a saturating event count.

module qpu_exu_flush_ctrl
  import qpu_exu_flush_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             brchmis_flush_req,
  output logic             brchmis_flush_ack,
  input  logic [PC_W-1:0]  brchmis_flush_add_op1,
  input  logic [PC_W-1:0]  brchmis_flush_add_op2,
  input  logic             redir_flush_req,
  output logic             redir_flush_ack,
  input  logic [PC_W-1:0]  redir_flush_pc,
  output logic             ifu_flush_req,
  output logic [PC_W-1:0]  ifu_flush_pc,
  input  logic             ifu_flush_ack,
  output logic             pipe_flush_pulse,
  output logic             flush_busy,
  output logic [CNT_W-1:0] flush_cnt
);

  flush_state_e     state_q;
  flush_state_e     state_d;
  logic             state_bit_q;
  logic             accept;
  logic [PC_W-1:0]  brch_tgt;
  logic [PC_W-1:0]  pc_d;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_en;

  // The only PC adder in the block; wraps at the PC width.
  assign brch_tgt = brchmis_flush_add_op1 + brchmis_flush_add_op2;

  always_comb begin
    state_d           = state_q;
    brchmis_flush_ack = 1'b0;
    redir_flush_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        brchmis_flush_ack = brchmis_flush_req;
        redir_flush_ack   = redir_flush_req & ~brchmis_flush_req;
        if (brchmis_flush_req | redir_flush_req) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ifu_flush_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = brchmis_flush_ack | redir_flush_ack;
  assign pc_d   = brchmis_flush_req ? brch_tgt : redir_flush_pc;
  assign cnt_en = accept & ~(&cnt_q);
  assign cnt_d  = cnt_q + CNT_W'(1);

  qpu_gnrl_dfflr #(.DW(1)) u_state_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (1'b1),
    .dnxt  (state_d),
    .qout  (state_bit_q)
  );

  assign state_q = flush_state_e'(state_bit_q);

  qpu_gnrl_dfflr #(.DW(PC_W)) u_pc_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (accept),
    .dnxt  (pc_d),
    .qout  (pc_q)
  );

  qpu_gnrl_dfflr #(.DW(CNT_W)) u_cnt_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (cnt_en),
    .dnxt  (cnt_d),
    .qout  (cnt_q)
  );

  assign ifu_flush_req    = (state_q == ST_REQ);
  assign flush_busy       = (state_q == ST_REQ);
  assign ifu_flush_pc     = pc_q;
  assign flush_cnt        = cnt_q;
  assign pipe_flush_pulse = accept;

endmodule

`default_nettype wire

// File: tb/tb_qpu_exu_flush_ctrl.sv
`default_nettype none
// tb_qpu_exu_flush_ctrl: directed scenarios plus randomized traffic against a behavioural model.

module tb_qpu_exu_flush_ctrl;
  import qpu_exu_flush_ctrl_pkg::PC_W;

  localparam int CW_S = 2;
  localparam int CW_L = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic brch_req  = 1'b0;
  logic redir_req = 1'b0;
  logic ifu_ack   = 1'b0;
  logic [PC_W-1:0] op1 = '0;
  logic [PC_W-1:0] op2 = '0;
  logic [PC_W-1:0] rpc = '0;

  logic s_back, s_rack, s_ifreq, s_pulse, s_busy;
  logic [PC_W-1:0] s_pc;
  logic [CW_S-1:0] s_cnt;
  logic l_back, l_rack, l_ifreq, l_pulse, l_busy;
  logic [PC_W-1:0] l_pc;
  logic [CW_L-1:0] l_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qpu_exu_flush_ctrl #(.CNT_W(CW_S)) u_dut_s (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .brchmis_flush_req     (brch_req),
    .brchmis_flush_ack     (s_back),
    .brchmis_flush_add_op1 (op1),
    .brchmis_flush_add_op2 (op2),
    .redir_flush_req       (redir_req),
    .redir_flush_ack       (s_rack),
    .redir_flush_pc        (rpc),
    .ifu_flush_req         (s_ifreq),
    .ifu_flush_pc          (s_pc),
    .ifu_flush_ack         (ifu_ack),
    .pipe_flush_pulse      (s_pulse),
    .flush_busy            (s_busy),
    .flush_cnt             (s_cnt)
  );

  qpu_exu_flush_ctrl #(.CNT_W(CW_L)) u_dut_l (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .brchmis_flush_req     (brch_req),
    .brchmis_flush_ack     (l_back),
    .brchmis_flush_add_op1 (op1),
    .brchmis_flush_add_op2 (op2),
    .redir_flush_req       (redir_req),
    .redir_flush_ack       (l_rack),
    .redir_flush_pc        (rpc),
    .ifu_flush_req         (l_ifreq),
    .ifu_flush_pc          (l_pc),
    .ifu_flush_ack         (ifu_ack),
    .pipe_flush_pulse      (l_pulse),
    .flush_busy            (l_busy),
    .flush_cnt             (l_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding flush at most, its target, and how many were accepted.
  bit     m_out = 1'b0;
  longint m_pc  = 0;
  int     m_n   = 0;

  function automatic longint sat(input int n, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (longint'(n) > lim) ? lim : longint'(n);
  endfunction

  always @(negedge rst_n) begin
    m_out = 1'b0;
    m_pc  = 0;
    m_n   = 0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_out) begin
        if (ifu_ack) m_out = 1'b0;
      end else if (brch_req) begin
        m_out = 1'b1;
        m_pc  = (longint'(op1) + longint'(op2)) & ((longint'(1) << PC_W) - 1);
        m_n++;
      end else if (redir_req) begin
        m_out = 1'b1;
        m_pc  = longint'(rpc);
        m_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit exp_b, exp_r;
      exp_b = !m_out && brch_req;
      exp_r = !m_out && redir_req && !brch_req;
      chk("brch_ack",  s_back,  exp_b);
      chk("redir_ack", s_rack,  exp_r);
      chk("pulse",     s_pulse, exp_b || exp_r);
      chk("ifu_req",   s_ifreq, m_out);
      chk("busy",      s_busy,  m_out);
      chk("ifu_pc",    s_pc,    m_pc);
      chk("cnt_w2",    s_cnt,   sat(m_n, CW_S));
      chk("L_brch_ack",  l_back,  exp_b);
      chk("L_redir_ack", l_rack,  exp_r);
      chk("L_pulse",     l_pulse, exp_b || exp_r);
      chk("L_ifu_req",   l_ifreq, m_out);
      chk("L_busy",      l_busy,  m_out);
      chk("L_ifu_pc",    l_pc,    m_pc);
      chk("cnt_w16",     l_cnt,   sat(m_n, CW_L));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ifu_req", s_ifreq, 0);
    chk("rst_busy",    s_busy,  0);
    chk("rst_pc",      s_pc,    0);
    chk("rst_cnt",     s_cnt,   0);

    // Branch flush: 0x100 + 0x20, IFU acks on the third REQ cycle.
    @(posedge clk);
    cyc();
    rst_n = 1'b1; brch_req = 1'b1; op1 = 32'h100; op2 = 32'h20;
    at_neg();
    chk("t1_brch_ack", s_back, 1);
    chk("t1_pulse",    s_pulse, 1);
    chk("t1_redir_ack", s_rack, 0);
    cyc();
    brch_req = 1'b0;
    at_neg();
    chk("t1_ifu_req", s_ifreq, 1);
    chk("t1_ifu_pc",  s_pc, 32'h120);
    chk("t1_pulse_off", s_pulse, 0);
    cyc();
    cyc();
    ifu_ack = 1'b1;
    at_neg();
    chk("t1_req_in_ack", s_ifreq, 1);
    cyc();
    ifu_ack = 1'b0;
    at_neg();
    chk("t1_idle_req", s_ifreq, 0);
    chk("t1_idle_busy", s_busy, 0);
    chk("t1_cnt", s_cnt, 1);
    chk("t1_pc_kept", s_pc, 32'h120);

    // Simultaneous requests: branch wins, redirect waits past the IFU ack cycle.
    cyc();
    brch_req = 1'b1; op1 = 32'h40; op2 = 32'h4; redir_req = 1'b1; rpc = 32'h800;
    at_neg();
    chk("t2_brch_ack", s_back, 1);
    chk("t2_redir_ack", s_rack, 0);
    cyc();
    brch_req = 1'b0; ifu_ack = 1'b1;
    at_neg();
    chk("t2_ifu_pc", s_pc, 32'h44);
    chk("t2_redir_in_ack", s_rack, 0);
    cyc();
    ifu_ack = 1'b0;
    at_neg();
    chk("t2_redir_ack", s_rack, 1);
    chk("t2_pulse", s_pulse, 1);
    cyc();
    redir_req = 1'b0;
    at_neg();
    chk("t2_ifu_pc2", s_pc, 32'h800);
    cyc();
    ifu_ack = 1'b1;
    cyc();
    ifu_ack = 1'b0;

    // Wrap-around target, then a long-held REQ with requesters pushing.
    brch_req = 1'b1; op1 = '1; op2 = 32'h2;
    cyc();
    brch_req = 1'b0;
    at_neg();
    chk("t3_wrap_pc", s_pc, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      brch_req = 1'b1; redir_req = 1'b1; op1 = $urandom; rpc = $urandom;
      at_neg();
      chk("t4_hold_pc",  s_pc, 1);
      chk("t4_hold_back", s_back, 0);
      chk("t4_hold_rack", s_rack, 0);
    end
    cyc();
    brch_req = 1'b0; redir_req = 1'b0; ifu_ack = 1'b1;
    cyc();
    ifu_ack = 1'b0;

    // Fifth acceptance: narrow counter saturates, wide one keeps counting.
    redir_req = 1'b1; rpc = 32'h200;
    cyc();
    redir_req = 1'b0;
    at_neg();
    chk("t5_cnt_sat", s_cnt, 3);
    chk("t5_cnt_wide", l_cnt, 5);

    // Reset while a flush is outstanding: outputs clear with no clock edge.
    chk("t6_pre_rst_req", s_ifreq, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",  s_ifreq, 0);
    chk("t6_rst_busy", s_busy, 0);
    chk("t6_rst_cnt",  s_cnt, 0);
    chk("t6_rst_cnt_l", l_cnt, 0);
    cyc();
    at_neg();
    chk("t6_abandoned", s_ifreq, 0);
    chk("t6_pc_zero", s_pc, 0);
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      brch_req  = ($urandom_range(0, 9) < 4);
      redir_req = ($urandom_range(0, 9) < 4);
      ifu_ack   = ($urandom_range(0, 9) < 4);
      op1 = (i % 50 == 0) ? '1 : PC_W'($urandom);
      op2 = PC_W'($urandom);
      rpc = PC_W'($urandom);
      cyc();
    end
    brch_req = 1'b0; redir_req = 1'b0; ifu_ack = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
